// File: rtl/snn_spi_pkg.sv
// snn_spi_pkg
//   Shared constants, state encoding and frame helper for the SNN SPI
//   register-interface initiator.
//   Frame layout (MSB first): [15] W (1 = write), [14:8] address, [7:0] data.
package snn_spi_pkg;

    localparam int FRAME_W = 16;
    localparam int RW_BIT  = 15;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    localparam logic SPI_WR = 1'b1;
    localparam logic SPI_RD = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } spi_m_state_t;

    // Reads put zeros in the data field; the slave owns miso during it.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {wr, addr, (wr == SPI_WR) ? wdata : {DATA_W{1'b0}}};
    endfunction

endpackage

// File: rtl/snn_spi_sclk_div.sv
// snn_spi_sclk_div
//   Half-period divider shared by every timed state of the SPI initiator.
//   The counter runs 0..CLK_DIV-1 while en is high and parks at 0 otherwise,
//   so each state entered from IDLE or from a wrap starts a fresh half period.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   en        count enable (high whenever the initiator is not idle)
//   half_last high in the last clk cycle of the current half period
//   wrap      half_last qualified by en; advances the initiator state
module snn_spi_sclk_div
    import snn_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic half_last,
    output logic wrap
);

    localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
        end else if (half_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign half_last = (cnt == CNT_MAX);
    assign wrap      = en && half_last;

endmodule

// File: rtl/snn_spi_master.sv
// snn_spi_master
//   Mode-0 SPI initiator for the SNN core register interface. One request
//   produces one 16-bit frame: SETUP (cs_n low, sclk low), 16 x (high half,
//   low half), HOLD, then an inter-frame GAP with cs_n high. Every timed
//   phase lasts CLK_DIV clk cycles, so cs_n is low for 34*CLK_DIV cycles.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, wr, addr,    request; sampled only while busy=0
//   wdata
//   busy                high from the cycle after start through the gap
//   done                one-cycle pulse on the cycle cs_n returns high
//   rdata               data of the last completed read
//   sclk, cs_n, mosi    SPI outputs (registered)
//   miso                SPI input, sampled just before each sclk fall
module snn_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    import snn_spi_pkg::*;

    spi_m_state_t        state;
    logic [FRAME_W-1:0]  tx;        // tx[FRAME_W-1] is the bit on mosi
    logic [DATA_W-1:0]   rx;        // last DATA_W miso samples
    logic [3:0]          bit_cnt;   // frame bit currently on the wire
    logic                is_rd;
    logic [FRAME_W-1:0]  req_frame;
    logic                div_en;
    logic                half_last;
    logic                wrap;

    assign req_frame = build_frame(wr, addr, wdata);
    assign div_en    = (state != IDLE);

    snn_spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (div_en),
        .half_last (half_last),
        .wrap      (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            is_rd   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx      <= req_frame;
                        is_rd   <= (wr == SPI_RD);
                        cs_n    <= 1'b0;
                        mosi    <= req_frame[RW_BIT];
                        sclk    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= 4'd15;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (wrap) begin
                        sclk  <= 1'b1;
                        state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    // Sample as late as possible in the high half so the
                    // slave has the whole half period to settle miso.
                    if (half_last) begin
                        rx <= {rx[DATA_W-2:0], miso};
                    end
                    if (wrap) begin
                        sclk  <= 1'b0;
                        tx    <= {tx[FRAME_W-2:0], 1'b0};
                        mosi  <= tx[FRAME_W-2];
                        state <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (wrap) begin
                        if (bit_cnt == 4'd0) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            sclk    <= 1'b1;
                            state   <= SHIFT_HI;
                        end
                    end
                end
                HOLD: begin
                    if (wrap) begin
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
                        done  <= 1'b1;
                        if (is_rd) begin
                            rdata <= rx;
                        end
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (wrap) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_spi_master.sv
// tb_snn_spi_master
//   Two initiators (CLK_DIV 4 and 255), each with a mode-0 slave model that
//   returns {8'h00, resp} on miso. A frame-level model predicts every output
//   on every cycle from the position k inside the current frame; directed
//   requests add hand-computed literal expectations.
module tb_snn_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n, start, wr;
    logic [1:0][6:0] addr;
    logic [1:0][7:0] wdata, resp;
    logic [1:0]      busy_w, done_w, sclk_w, cs_n_w, mosi_w;
    logic [1:0][7:0] rdata_w;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic int div_of(input int g);
        return (g == 0) ? 4 : 255;
    endfunction

    task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_assert++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        logic        miso = 1'b0;
        logic [15:0] sr   = '0;

        snn_spi_master #(
            .CLK_DIV ((g == 0) ? 4 : 255),
            .ADDR_W  (7),
            .DATA_W  (8)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n[g]),
            .start (start[g]),
            .wr    (wr[g]),
            .addr  (addr[g]),
            .wdata (wdata[g]),
            .busy  (busy_w[g]),
            .done  (done_w[g]),
            .rdata (rdata_w[g]),
            .sclk  (sclk_w[g]),
            .cs_n  (cs_n_w[g]),
            .mosi  (mosi_w[g]),
            .miso  (miso)
        );

        // Mode-0 slave: first bit valid at cs_n fall, next bit on each sclk fall.
        always @(negedge cs_n_w[g]) begin
            sr   = {8'h00, resp[g]};
            miso = sr[15];
        end
        always @(negedge sclk_w[g]) begin
            if (!cs_n_w[g]) begin
                sr   = {sr[14:0], 1'b0};
                miso = sr[15];
            end
        end
    end

    // Frame model: k = cycles since the start was accepted (k=1 first busy cycle).
    bit          act[2];
    int          kk[2];
    bit          m_rd[2];
    logic [15:0] m_frame[2];
    logic [7:0]  m_resp[2];
    logic [7:0]  m_rexp[2];

    always @(posedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n[g]) begin
                act[g]    = 1'b0;
                kk[g]     = 0;
                m_rexp[g] = 8'h00;
            end else if (!act[g]) begin
                if (start[g]) begin
                    act[g]     = 1'b1;
                    kk[g]      = 1;
                    m_rd[g]    = !wr[g];
                    m_frame[g] = {wr[g], addr[g], wr[g] ? wdata[g] : 8'h00};
                    m_resp[g]  = resp[g];
                end
            end else if (kk[g] == 35 * div_of(g)) begin
                act[g] = 1'b0;
            end else begin
                if (kk[g] == 34 * div_of(g) && m_rd[g]) m_rexp[g] = m_resp[g];
                kk[g]++;
            end
        end
    end

    // Monitors shared with the directed checks.
    int          edges[2], low_cnt[2], done_cnt[2], falls[2], last_fall[2], run[2];
    logic [15:0] cap[2];
    logic        prev_cs[2], prev_sclk[2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            edges[g] = 0; low_cnt[g] = 0; done_cnt[g] = 0; falls[g] = 0;
            last_fall[g] = 0; run[g] = 0; cap[g] = '0;
            prev_cs[g] = 1'b1; prev_sclk[g] = 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        int   d, k, m, half, bi;
        logic e_cs, e_sclk, e_busy, e_done;
        if (cyc >= 1) begin
            for (int g = 0; g < 2; g++) begin
                d      = div_of(g);
                k      = kk[g];
                e_cs   = !(act[g] && k >= 1 && k <= 34 * d);
                e_busy = act[g];
                e_done = act[g] && (k == 34 * d + 1);
                e_sclk = 1'b0;
                half   = 0;
                if (act[g] && k >= d + 1 && k <= 33 * d) begin
                    m      = k - 1 - d;
                    half   = m / d;
                    e_sclk = (half % 2 == 0);
                end
                check("cs_n", cs_n_w[g], e_cs);
                check("sclk", sclk_w[g], e_sclk);
                check("busy", busy_w[g], e_busy);
                check("done", done_w[g], e_done);
                check("rdata", rdata_w[g], m_rexp[g]);
                if (e_cs) begin
                    check("mosi_idle", mosi_w[g], 1'b0);
                end else if (k <= d) begin
                    check("mosi_setup", mosi_w[g], m_frame[g][15]);
                end else if (k <= 33 * d) begin
                    bi = half / 2;
                    if (half % 2 == 0) check("mosi_hi", mosi_w[g], m_frame[g][15-bi]);
                    else if (bi < 15)  check("mosi_lo", mosi_w[g], m_frame[g][14-bi]);
                end

                // Monitors
                if (prev_cs[g] && !cs_n_w[g]) begin
                    falls[g]++;
                    last_fall[g] = cyc;
                    cap[g]       = '0;
                    edges[g]     = 0;
                    low_cnt[g]   = 0;
                end
                if (!cs_n_w[g]) low_cnt[g]++;
                if (!prev_sclk[g] && sclk_w[g]) begin
                    edges[g]++;
                    cap[g] = {cap[g][14:0], mosi_w[g]};
                end
                if (!cs_n_w[g]) begin
                    if (sclk_w[g] != prev_sclk[g]) begin
                        check("sclk_phase_len", run[g], d);
                        run[g] = 1;
                    end else begin
                        run[g]++;
                    end
                end else begin
                    run[g] = 0;
                end
                if (done_w[g]) done_cnt[g]++;
                prev_cs[g]   = cs_n_w[g];
                prev_sclk[g] = sclk_w[g];
            end
        end
    end

    task automatic wait_idle(input int g);
        for (int i = 0; i < 40 * div_of(g); i++) begin
            if (!busy_w[g]) return;
            @(negedge clk);
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic req(input int g, input logic w, input logic [6:0] a,
                       input logic [7:0] wd, input logic [7:0] rs, output int s);
        wait_idle(g);
        @(negedge clk);
        wr[g] = w; addr[g] = a; wdata[g] = wd; resp[g] = rs; start[g] = 1'b1;
        s = cyc;
        @(negedge clk);
        // Scramble the request bus to show the frame was latched at start.
        start[g] = 1'b0; wr[g] = ~w; addr[g] = ~a; wdata[g] = ~wd;
    endtask

    task automatic wait_done(input int g, output int dc);
        dc = -1;
        for (int i = 0; i < 40 * div_of(g); i++) begin
            @(negedge clk);
            #1;
            if (done_w[g]) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) check("done_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s, dc, d1, lf, f0, dc0;
        rst_n = 2'b00; start = '0; wr = '0; addr = '0; wdata = '0; resp = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n", cs_n_w[0], 1'b1);
        check("rst_sclk", sclk_w[0], 1'b0);
        check("rst_busy", busy_w[0], 1'b0);
        check("rst_rdata", rdata_w[0], 8'h00);
        check("rst_cs_n_255", cs_n_w[1], 1'b1);
        rst_n = 2'b11;
        @(negedge clk);

        // Write 0x05 <- 0xA5
        req(0, 1'b1, 7'h05, 8'hA5, 8'h00, s);
        wait_done(0, dc);
        check("wr_mosi_frame", cap[0], 16'h85A5);
        check("wr_edges", edges[0], 16);
        check("wr_cs_low_cycles", low_cnt[0], 136);
        check("wr_done_cycle", dc - s, 137);
        check("wr_rdata", rdata_w[0], 8'h00);

        // Read 0x12, slave returns 0x3C
        req(0, 1'b0, 7'h12, 8'hEE, 8'h3C, s);
        wait_done(0, dc);
        check("rd_mosi_frame", cap[0], 16'h1200);
        check("rd_edges", edges[0], 16);
        check("rd_rdata", rdata_w[0], 8'h3C);

        // A write afterwards leaves rdata alone
        req(0, 1'b1, 7'h01, 8'h77, 8'hC3, s);
        wait_done(0, dc);
        check("wr2_mosi_frame", cap[0], 16'h8177);
        check("wr2_rdata_kept", rdata_w[0], 8'h3C);

        // Back-to-back with start held high
        wait_idle(0);
        @(negedge clk);
        f0 = falls[0];
        wr[0] = 1'b1; addr[0] = 7'h22; wdata[0] = 8'h11; start[0] = 1'b1;
        wait_done(0, d1);
        lf = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            if (falls[0] == f0 + 2) break;
        end
        lf = last_fall[0];
        check("b2b_second_frame", falls[0] - f0, 2);
        check("b2b_done_to_cs_fall", lf - d1, 5);
        wait_done(0, dc);
        start[0] = 1'b0;
        check("b2b_second_cs_low", dc - lf, 136);
        check("b2b_mosi_frame", cap[0], 16'hA211);

        // start pulses while busy are ignored
        wait_idle(0);
        f0 = falls[0]; dc0 = done_cnt[0];
        req(0, 1'b1, 7'h40, 8'h5A, 8'h00, s);
        wr[0] = 1'b0; addr[0] = 7'h7E;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            start[0] = (i == 20 || i == 60 || i == 100);
        end
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("busy_start_frames", falls[0] - f0, 1);
        check("busy_start_dones", done_cnt[0] - dc0, 1);

        // Reset in the middle of a read
        wait_idle(0);
        dc0 = done_cnt[0];
        req(0, 1'b0, 7'h33, 8'h00, 8'h5A, s);
        while (cyc < s + 50) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_cs_n", cs_n_w[0], 1'b1);
        check("midrst_sclk", sclk_w[0], 1'b0);
        check("midrst_busy", busy_w[0], 1'b0);
        check("midrst_rdata", rdata_w[0], 8'h00);
        rst_n[0] = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        check("midrst_no_done", done_cnt[0] - dc0, 0);

        req(0, 1'b0, 7'h44, 8'h00, 8'h96, s);
        wait_done(0, dc);
        check("postrst_edges", edges[0], 16);
        check("postrst_mosi_frame", cap[0], 16'h4400);
        check("postrst_rdata", rdata_w[0], 8'h96);

        req(0, 1'b0, 7'h00, 8'h00, 8'hFF, s);
        wait_done(0, dc);
        check("div4_rd_ff", rdata_w[0], 8'hFF);

        // Slow divider
        req(1, 1'b0, 7'h7F, 8'h00, 8'hFF, s);
        wait_done(1, dc);
        check("div255_rd_ff", rdata_w[1], 8'hFF);
        check("div255_edges", edges[1], 16);
        check("div255_mosi_frame", cap[1], 16'h7F00);
        check("div255_cs_low_cycles", low_cnt[1], 8670);
        check("div255_done_cycle", dc - s, 8671);

        req(1, 1'b0, 7'h00, 8'h00, 8'h00, s);
        wait_done(1, dc);
        check("div255_rd_00", rdata_w[1], 8'h00);
        check("div255_edges2", edges[1], 16);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
